// File: rtl/bitop_pipe.sv
// Eight-operation W-bit bit-wise/arithmetic unit with a DEPTH-stage elastic
// pipeline, valid/ready on both sides, bubble collapse and full backpressure.
module bitop_pipe #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         carry,
    output logic         zero
);

    localparam logic [2:0] OP_XOR    = 3'b000;
    localparam logic [2:0] OP_AND    = 3'b001;
    localparam logic [2:0] OP_OR     = 3'b010;
    localparam logic [2:0] OP_XNOR   = 3'b011;
    localparam logic [2:0] OP_ADD    = 3'b100;
    localparam logic [2:0] OP_SUB    = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [2:0] OP_PASS_B = 3'b111;

    // Result is {carry, y}; for SUB the extra bit is the borrow (a < b).
    function automatic logic [W:0] alu_f(input logic [2:0] op_i,
                                         input logic [W-1:0] a_i,
                                         input logic [W-1:0] b_i);
        logic [W:0] r;
        r = {(W+1){1'b0}};
        case (op_i)
            OP_XOR:    r = {1'b0, a_i ^ b_i};
            OP_AND:    r = {1'b0, a_i & b_i};
            OP_OR:     r = {1'b0, a_i | b_i};
            OP_XNOR:   r = {1'b0, ~(a_i ^ b_i)};
            OP_ADD:    r = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:    r = {1'b0, a_i} - {1'b0, b_i};
            OP_PASS_A: r = {1'b0, a_i};
            OP_PASS_B: r = {1'b0, b_i};
            default:   r = {(W+1){1'b0}};
        endcase
        return r;
    endfunction

    logic [DEPTH-1:0]          vld_q, vld_d;
    logic [DEPTH-1:0][W-1:0]   y_q, y_d;
    logic [DEPTH-1:0]          c_q, c_d;
    logic [DEPTH-1:0]          z_q, z_d;
    logic [DEPTH-1:0]          open_s;
    logic                      full_s;
    logic [W:0]                res_s;

    // A stage is blocked only when it and every stage after it hold data and the consumer stalls.
    always_comb begin
        open_s = {DEPTH{1'b0}};
        full_s = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            full_s = 1'b1;
            for (int j = k; j < DEPTH; j++) begin
                full_s = full_s & vld_q[j];
            end
            open_s[k] = ~full_s | out_ready;
        end
    end

    // Stage 1 captures the computed result; later stages shift forward when open.
    always_comb begin
        res_s = alu_f(op, a, b);
        vld_d = vld_q;
        y_d   = y_q;
        c_d   = c_q;
        z_d   = z_q;
        if (open_s[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                y_d[0] = res_s[W-1:0];
                c_d[0] = res_s[W];
                z_d[0] = (res_s[W-1:0] == {W{1'b0}});
            end else begin
                y_d[0] = y_q[0];
            end
        end else begin
            vld_d[0] = vld_q[0];
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (open_s[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    y_d[k] = y_q[k-1];
                    c_d[k] = c_q[k-1];
                    z_d[k] = z_q[k-1];
                end else begin
                    y_d[k] = y_q[k];
                end
            end else begin
                vld_d[k] = vld_q[k];
            end
        end
    end

    // Pipeline state registers; reset empties every stage and clears its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= {DEPTH{1'b0}};
            y_q   <= {(DEPTH*W){1'b0}};
            c_q   <= {DEPTH{1'b0}};
            z_q   <= {DEPTH{1'b0}};
        end else begin
            vld_q <= vld_d;
            y_q   <= y_d;
            c_q   <= c_d;
            z_q   <= z_d;
        end
    end

    assign in_ready  = open_s[0];
    assign out_valid = vld_q[DEPTH-1];
    assign y         = y_q[DEPTH-1];
    assign carry     = c_q[DEPTH-1];
    assign zero      = z_q[DEPTH-1];

endmodule
